// File: rtl/framebuffer_writer_pkg.sv
// Shared constants and helpers for the panel framebuffer write path.
// The word layout here is the one the panel scan engine reads back.
package framebuffer_writer_pkg;

   localparam int FB_ADDR_W = 12;
   localparam int FB_DATA_W = 16;
   localparam int COL_W     = 6;
   localparam int ROW_W     = 5;

   // Per-channel bit positions; *_TOP for rows 0..31, *_BOT for rows 32..63
   localparam int R_TOP = 15;
   localparam int R_BOT = 14;
   localparam int G_TOP = 13;
   localparam int G_BOT = 12;
   localparam int B_TOP = 11;
   localparam int B_BOT = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_CLR
   } fbw_state_e;

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
   } rgb222_t;

   function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic             plane,
                                                    input logic [ROW_W-1:0] y,
                                                    input logic [COL_W-1:0] x);
      return {plane, y, x};
   endfunction

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel stream, clear control and RAM port bundle of the framebuffer writer.
// slave is the writer's view; master is the pixel source / RAM side.
interface framebuffer_writer_if;
   import framebuffer_writer_pkg::*;

   logic                 i_pix_valid;
   logic                 o_pix_ready;
   logic                 i_pix_sof;
   logic [1:0]           i_pix_r;
   logic [1:0]           i_pix_g;
   logic [1:0]           i_pix_b;
   logic                 i_clear;
   logic                 o_busy;
   logic                 o_frame_done;
   logic [FB_ADDR_W-1:0] o_ram_raddr;
   logic [FB_DATA_W-1:0] i_ram_rdata;
   logic [FB_ADDR_W-1:0] o_ram_waddr;
   logic [FB_DATA_W-1:0] o_ram_wdata;
   logic                 o_ram_we;

   modport slave (
      input  i_pix_valid, i_pix_sof, i_pix_r, i_pix_g, i_pix_b, i_clear, i_ram_rdata,
      output o_pix_ready, o_busy, o_frame_done, o_ram_raddr, o_ram_waddr, o_ram_wdata, o_ram_we
   );

   modport master (
      output i_pix_valid, i_pix_sof, i_pix_r, i_pix_g, i_pix_b, i_clear, i_ram_rdata,
      input  o_pix_ready, o_busy, o_frame_done, o_ram_raddr, o_ram_waddr, o_ram_wdata, o_ram_we
   );

endinterface

// File: rtl/framebuffer_writer.sv
// Raster-order RGB222 pixel writer into the two bit-plane framebuffer.
// Each pixel is a read-modify-write of both planes; also clears the whole buffer.
module framebuffer_writer
   import framebuffer_writer_pkg::*;
#(
   parameter int COLS      = 64,
   parameter int HALF_ROWS = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   framebuffer_writer_if.slave  fb
);

   localparam logic [COL_W-1:0] X_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W:0]   Y_LAST = (ROW_W + 1)'(2 * HALF_ROWS - 1);

   fbw_state_e           state_q, state_d;
   logic [COL_W-1:0]     x_q, cx_q, ax;
   logic [ROW_W:0]       y_q, cy_q, ay;
   rgb222_t              pix_q;
   logic                 clear_pend_q;
   logic [FB_ADDR_W-1:0] clr_addr_q;
   logic                 frame_done_q;
   logic                 accept;

   logic [FB_ADDR_W-1:0] raddr, waddr;
   logic [FB_DATA_W-1:0] wdata;
   logic                 we;

   // Only the addressed half's three bits change; the other half and [9:0] pass through.
   function automatic logic [FB_DATA_W-1:0] merge_px(input logic [FB_DATA_W-1:0] word,
                                                     input logic                 bot,
                                                     input logic                 plane,
                                                     input rgb222_t              px);
      logic [FB_DATA_W-1:0] w;
      w = word;
      if (bot) begin
         w[R_BOT] = px.r[plane];
         w[G_BOT] = px.g[plane];
         w[B_BOT] = px.b[plane];
      end else begin
         w[R_TOP] = px.r[plane];
         w[G_TOP] = px.g[plane];
         w[B_TOP] = px.b[plane];
      end
      return w;
   endfunction

   assign fb.o_pix_ready = (state_q == ST_IDLE) & ~fb.i_clear & ~clear_pend_q;
   assign fb.o_busy      = (state_q != ST_IDLE) | clear_pend_q;
   assign accept         = fb.i_pix_valid & fb.o_pix_ready;

   // SOF overrides the running position for the pixel being accepted
   assign ax = fb.i_pix_sof ? '0 : x_q;
   assign ay = fb.i_pix_sof ? '0 : y_q;

   always_comb begin
      state_d = state_q;
      raddr   = '0;
      waddr   = '0;
      wdata   = '0;
      we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fb.i_clear | clear_pend_q) begin
               state_d = ST_CLR;
            end else if (fb.i_pix_valid) begin
               state_d = ST_RD0;
               raddr   = fb_addr(1'b0, ay[ROW_W-1:0], ax);
            end
         end
         ST_RD0: begin
            raddr   = fb_addr(1'b1, cy_q[ROW_W-1:0], cx_q);
            waddr   = fb_addr(1'b0, cy_q[ROW_W-1:0], cx_q);
            wdata   = merge_px(fb.i_ram_rdata, cy_q[ROW_W], 1'b0, pix_q);
            we      = 1'b1;
            state_d = ST_RD1;
         end
         ST_RD1: begin
            waddr   = fb_addr(1'b1, cy_q[ROW_W-1:0], cx_q);
            wdata   = merge_px(fb.i_ram_rdata, cy_q[ROW_W], 1'b1, pix_q);
            we      = 1'b1;
            state_d = ST_IDLE;
         end
         ST_CLR: begin
            waddr = clr_addr_q;
            we    = 1'b1;
            if (clr_addr_q == '1) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign fb.o_ram_raddr  = raddr;
   assign fb.o_ram_waddr  = waddr;
   assign fb.o_ram_wdata  = wdata;
   assign fb.o_ram_we     = we;
   assign fb.o_frame_done = frame_done_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         pix_q        <= '0;
         clear_pend_q <= 1'b0;
         clr_addr_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= (state_q == ST_RD1) && (cx_q == X_LAST) && (cy_q == Y_LAST);

         if (accept) begin
            cx_q  <= ax;
            cy_q  <= ay;
            pix_q <= {fb.i_pix_r, fb.i_pix_g, fb.i_pix_b};
         end

         if (state_q == ST_RD1) begin
            if (cx_q == X_LAST) begin
               x_q <= '0;
               y_q <= (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
               x_q <= cx_q + 1'b1;
               y_q <= cy_q;
            end
         end

         // A pending clear is consumed on the IDLE cycle that launches it; CLR ignores new clears
         if (state_q == ST_IDLE)
            clear_pend_q <= 1'b0;
         else if (state_q != ST_CLR && fb.i_clear)
            clear_pend_q <= 1'b1;

         if (state_q == ST_CLR) begin
            clr_addr_q <= clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
               x_q <= '0;
               y_q <= '0;
            end
         end else begin
            clr_addr_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Random-stream bench for framebuffer_writer: a RAM model, an operation-level
// reference of the framebuffer contents, and a per-cycle output compare.
module tb_framebuffer_writer;
   import framebuffer_writer_pkg::*;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   framebuffer_writer_if fb();

   framebuffer_writer #(.COLS(64), .HALF_ROWS(32)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .fb      (fb.slave)
   );

   // Bench RAM: 1-cycle read latency, written by the DUT or by bench preloads
   logic [15:0] tb_mem [4096];
   logic        mem_zero = 1'b0;
   logic        pre_we   = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [15:0] pre_data = '0;

   always @(posedge i_clk) begin
      if (mem_zero) begin
         for (int i = 0; i < 4096; i++) tb_mem[i] <= '0;
      end else if (pre_we) begin
         tb_mem[pre_addr] <= pre_data;
      end else if (fb.o_ram_we) begin
         tb_mem[fb.o_ram_waddr] <= fb.o_ram_wdata;
      end
      fb.i_ram_rdata <= tb_mem[fb.o_ram_raddr];
   end

   // Reference: queue of writes owed by accepted operations, data derived at write time
   typedef struct {
      logic [11:0] addr;
      logic        plane;
      logic        bot;
      logic [5:0]  rgb;
      logic        clr;
      logic        last;
   } wr_t;

   wr_t         q[$];
   logic [15:0] exp_mem [4096];
   int          mx, my;
   bit          clr_out, fd_due;
   int          mon_chk, mon_fail, lit_chk, lit_fail;
   int          fd_seen, wr_cnt;
   logic [11:0] wlog_last, wlog_prev;

   // Channel c (r,g,b) owns bits 15-2c (top) and 14-2c (bottom); plane p stores level bit p
   function automatic logic [15:0] model_word(input logic [15:0] old, input logic plane,
                                              input logic bot, input logic [5:0] rgb);
      logic [15:0] w;
      logic [1:0]  lvl;
      int          pos;
      w = old;
      for (int c = 0; c < 3; c++) begin
         lvl = rgb[5 - 2*c -: 2];
         pos = 15 - 2*c - (bot ? 1 : 0);
         w[pos] = lvl[plane];
      end
      return w;
   endfunction

   task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      mon_chk++;
      if (act !== exp) begin
         mon_fail++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic lchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      lit_chk++;
      if (act !== exp) begin
         lit_fail++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge i_clk) begin
      wr_t         e;
      logic [15:0] ev;
      if (mem_zero) begin
         for (int i = 0; i < 4096; i++) exp_mem[i] = '0;
      end else if (pre_we) begin
         exp_mem[pre_addr] = pre_data;
      end
      if (!i_rst_n) begin
         q.delete();
         mx = 0; my = 0; clr_out = 0; fd_due = 0;
      end else begin
         mchk("ready", fb.o_pix_ready, (q.size() == 0) && !fb.i_clear);
         mchk("busy", fb.o_busy, q.size() != 0);
         mchk("frame_done", fb.o_frame_done, fd_due);
         if (fb.o_frame_done) fd_seen++;
         fd_due = 0;
         // Inputs are stable here and take effect at the coming rising edge
         if (fb.i_clear && !clr_out) begin
            for (int a = 0; a < 4096; a++) begin
               e = '{addr: 12'(a), plane: 1'b0, bot: 1'b0, rgb: 6'd0, clr: 1'b1, last: 1'b0};
               q.push_back(e);
            end
            clr_out = 1; mx = 0; my = 0;
         end else if (fb.i_pix_valid && fb.o_pix_ready) begin
            if (fb.i_pix_sof) begin mx = 0; my = 0; end
            for (int p = 0; p < 2; p++) begin
               e.addr  = 12'(p*2048 + (my % 32)*64 + mx);
               e.plane = (p == 1);
               e.bot   = (my >= 32);
               e.rgb   = {fb.i_pix_r, fb.i_pix_g, fb.i_pix_b};
               e.clr   = 1'b0;
               e.last  = (p == 1) && (mx == 63) && (my == 63);
               q.push_back(e);
            end
            mx++;
            if (mx == 64) begin mx = 0; my = (my + 1) % 64; end
         end
         if (fb.o_ram_we) begin
            if (q.size() == 0) begin
               mchk("unexpected_write", {20'd0, fb.o_ram_waddr}, 32'hFFFF_FFFF);
            end else begin
               e  = q.pop_front();
               ev = e.clr ? 16'h0000 : model_word(exp_mem[e.addr], e.plane, e.bot, e.rgb);
               mchk("waddr", fb.o_ram_waddr, e.addr);
               mchk("wdata", fb.o_ram_wdata, ev);
               mchk("raddr_ne_waddr", (!e.clr && fb.o_ram_raddr == fb.o_ram_waddr) ? 1 : 0, 0);
               exp_mem[e.addr] = ev;
               fd_due = e.last;
               if (e.clr && e.addr == 12'hFFF) clr_out = 0;
            end
            wr_cnt++;
            wlog_prev = wlog_last;
            wlog_last = fb.o_ram_waddr;
         end
      end
   end

   task automatic pulse_ctl(input logic zero, input logic [11:0] a, input logic [15:0] d);
      mem_zero = zero; pre_we = !zero; pre_addr = a; pre_data = d;
      @(posedge i_clk); @(negedge i_clk); #1;
      mem_zero = 1'b0; pre_we = 1'b0;
   endtask

   task automatic send_pixel(input bit sof, input logic [1:0] r, g, b, input int gap);
      bit done = 0;
      repeat (gap) begin @(posedge i_clk); #1; end
      fb.i_pix_valid = 1'b1; fb.i_pix_sof = sof;
      fb.i_pix_r = r; fb.i_pix_g = g; fb.i_pix_b = b;
      for (int i = 0; i < 50 && !done; i++) begin
         if (fb.o_pix_ready) done = 1;
         @(posedge i_clk); #1;
      end
      fb.i_pix_valid = 1'b0; fb.i_pix_sof = 1'b0;
      if (!done) lchk("pixel_accept_timeout", 0, 1);
   endtask

   task automatic send_rand(input int gap_max);
      send_pixel(0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom_range(0, gap_max));
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (!fb.o_busy) ok = 1;
         else begin @(posedge i_clk); #1; end
      end
      if (!ok) lchk("idle_timeout", 0, 1);
   endtask

   initial begin
      int n, w0, nz;
      fb.i_pix_valid = 0; fb.i_pix_sof = 0; fb.i_clear = 0;
      fb.i_pix_r = 0; fb.i_pix_g = 0; fb.i_pix_b = 0;
      pulse_ctl(1'b1, '0, '0);
      pulse_ctl(1'b0, 12'h001, 16'h03FF);
      pulse_ctl(1'b0, 12'h801, 16'h03FF);
      lchk("rst_we", fb.o_ram_we, 0);
      lchk("rst_raddr", fb.o_ram_raddr, 0);
      lchk("rst_waddr", fb.o_ram_waddr, 0);
      lchk("rst_wdata", fb.o_ram_wdata, 0);
      lchk("rst_frame_done", fb.o_frame_done, 0);
      lchk("rst_busy", fb.o_busy, 0);
      @(posedge i_clk); #1 i_rst_n = 1'b1;
      #1 lchk("ready_after_rst", fb.o_pix_ready, 1);

      // First pixel with SOF and a fixed colour; ready must drop for RD0 and RD1 only
      send_pixel(1, 2'd3, 2'd1, 2'd2, 0);
      n = 0;
      for (int i = 0; i < 10 && !fb.o_pix_ready; i++) begin n++; @(posedge i_clk); #1; end
      lchk("ready_low_cycles", n, 2);
      lchk("mem_000_top", tb_mem[12'h000], 16'hA000);
      lchk("mem_800_top", tb_mem[12'h800], 16'h8800);
      send_pixel(0, 2'd3, 2'd1, 2'd2, 0);
      wait_idle(20);
      lchk("mem_001_keep_low", tb_mem[12'h001], 16'hA3FF);
      lchk("mem_801_keep_low", tb_mem[12'h801], 16'h8BFF);

      for (int p = 2; p < 2048; p++) send_rand(2);
      send_pixel(0, 2'd3, 2'd1, 2'd2, 1);
      wait_idle(20);
      lchk("mem_000_both", tb_mem[12'h000], 16'hF000);
      lchk("mem_800_both", tb_mem[12'h800], 16'hCC00);
      for (int p = 2049; p < 4096; p++) send_rand(2);
      wait_idle(20);
      @(posedge i_clk); #1;
      lchk("frame_done_count", fd_seen, 1);
      send_rand(0);
      wait_idle(20);
      lchk("wrap_plane0_addr", wlog_prev, 12'h000);
      lchk("wrap_plane1_addr", wlog_last, 12'h800);

      // 98 more pixels, then SOF on the 100th of this frame
      for (int p = 0; p < 98; p++) send_rand(1);
      send_pixel(1, 2'd1, 2'd2, 2'd3, 0);
      wait_idle(20);
      lchk("sof_plane0_addr", wlog_prev, 12'h000);
      lchk("sof_plane1_addr", wlog_last, 12'h800);
      send_rand(0);
      wait_idle(20);
      lchk("after_sof_addr", wlog_prev, 12'h001);
      lchk("frame_done_no_extra", fd_seen, 1);

      // Clear raised while the writer sits in RD0
      send_rand(0);
      w0 = wr_cnt;
      fb.i_clear = 1'b1;
      @(posedge i_clk); #1 fb.i_clear = 1'b0;
      wait_idle(5000);
      lchk("clear_write_count", wr_cnt - w0, 4098);
      nz = 0;
      for (int i = 0; i < 4096; i++) if (tb_mem[i] != 16'h0) nz++;
      lchk("clear_nonzero_words", nz, 0);

      // Clear and valid together in IDLE: only the clear happens
      w0 = wr_cnt;
      fb.i_pix_valid = 1'b1; fb.i_pix_r = 2'd3; fb.i_clear = 1'b1;
      #1 lchk("collision_ready", fb.o_pix_ready, 0);
      @(posedge i_clk); #1 fb.i_pix_valid = 1'b0; fb.i_clear = 1'b0;
      wait_idle(5000);
      lchk("collision_write_count", wr_cnt - w0, 4096);
      send_rand(0);
      wait_idle(20);
      lchk("post_clear_addr", wlog_prev, 12'h000);
      lchk("frame_done_after_clears", fd_seen, 1);

      // Async reset in RD1 abandons the plane1 write and zeroes the counters
      send_rand(0);
      @(posedge i_clk); #1;
      lchk("rd1_we", fb.o_ram_we, 1);
      i_rst_n = 1'b0;
      #1 lchk("rst_mid_we", fb.o_ram_we, 0);
      lchk("rst_mid_busy", fb.o_busy, 0);
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      send_rand(0);
      wait_idle(20);
      lchk("post_rst_plane0", wlog_prev, 12'h000);
      lchk("post_rst_plane1", wlog_last, 12'h800);

      $display("End of test - %0d assertions evaluated, %0d failures",
               lit_chk + mon_chk, lit_fail + mon_fail);
      $finish;
   end

endmodule
